// File: rtl/sort_scheduler.sv
// Frame sorter: loads N words, sorts them descending with odd-even transposition
// through one external compare node, then drains them. Optional macro: SORT_EARLY_EXIT_EN.
module sort_scheduler #(
    parameter int N = 8,
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    input  logic [W-1:0] in_data,
    output logic         in_ready,
    output logic [W-1:0] cmp_a,
    output logic [W-1:0] cmp_b,
    input  logic [W-1:0] cmp_high,
    input  logic [W-1:0] cmp_low,
    output logic         out_valid,
    output logic [W-1:0] out_data,
    output logic         out_last,
    input  logic         out_ready,
    output logic         busy
);
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    localparam logic [1:0] ST_LOAD  = 2'd0;
    localparam logic [1:0] ST_SORT  = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    localparam logic [IW-1:0] IDX_LAST  = IW'(N - 1);
    localparam logic [IW-1:0] EVEN_LAST = IW'(N - 2);
    localparam logic [IW-1:0] ODD_LAST  = IW'(N - 3);

    logic [1:0]    state;
    logic [W-1:0]  frame [N];
    logic [IW-1:0] wr_idx;
    logic [IW-1:0] rd_idx;
    logic [IW-1:0] pass;
    logic [IW-1:0] pair;
    logic [IW-1:0] pair_nxt;
    logic          pass_end;
    logic          early_done;
    logic          sort_done;

    assign pair_nxt  = pair + 1'b1;
    assign pass_end  = (state == ST_SORT) && (pass[0] ? (pair == ODD_LAST) : (pair == EVEN_LAST));
    assign sort_done = pass_end && ((pass == IDX_LAST) || early_done);

    // Both ports transfer a word on a cycle where valid && ready; valid never
    // depends on ready, and out_data holds while out_valid && !out_ready.
    assign in_ready  = (state == ST_LOAD) && !rst;
    assign busy      = (state == ST_SORT) || (state == ST_DRAIN);
    assign cmp_a     = (state == ST_SORT) ? frame[pair] : '0;
    assign cmp_b     = (state == ST_SORT) ? frame[pair_nxt] : '0;
    assign out_valid = (state == ST_DRAIN);
    assign out_data  = out_valid ? frame[rd_idx] : '0;
    assign out_last  = out_valid && (rd_idx == IDX_LAST);

`ifdef SORT_EARLY_EXIT_EN
    logic swap_seen;
    logic swap_now;

    // A tie leaves cmp_high equal to cmp_a, so it never counts as a swap.
    assign swap_now   = (cmp_high != cmp_a);
    assign early_done = pass[0] && !(swap_seen || swap_now);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            swap_seen <= 1'b0;
        end else if (state != ST_SORT) begin
            swap_seen <= 1'b0;
        end else if (pass_end && pass[0]) begin
            swap_seen <= 1'b0;
        end else if (swap_now) begin
            swap_seen <= 1'b1;
        end
    end
`else
    assign early_done = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= ST_LOAD;
            wr_idx <= '0;
            rd_idx <= '0;
            pass   <= '0;
            pair   <= '0;
            for (int i = 0; i < N; i++) begin
                frame[i] <= '0;
            end
        end else begin
            case (state)
                ST_LOAD: begin
                    if (in_valid) begin
                        frame[wr_idx] <= in_data;
                        if (wr_idx == IDX_LAST) begin
                            wr_idx <= '0;
                            pass   <= '0;
                            pair   <= '0;
                            state  <= ST_SORT;
                        end else begin
                            wr_idx <= wr_idx + 1'b1;
                        end
                    end
                end
                ST_SORT: begin
                    // Larger value lands at the lower index, giving descending order.
                    frame[pair]     <= cmp_high;
                    frame[pair_nxt] <= cmp_low;
                    if (sort_done) begin
                        rd_idx <= '0;
                        state  <= ST_DRAIN;
                    end else if (pass_end) begin
                        pass <= pass + 1'b1;
                        pair <= pass[0] ? '0 : IW'(1);
                    end else begin
                        pair <= pair + IW'(2);
                    end
                end
                ST_DRAIN: begin
                    if (out_ready) begin
                        if (rd_idx == IDX_LAST) begin
                            rd_idx <= '0;
                            wr_idx <= '0;
                            state  <= ST_LOAD;
                        end else begin
                            rd_idx <= rd_idx + 1'b1;
                        end
                    end
                end
                default: state <= ST_LOAD;
            endcase
        end
    end
endmodule

// File: doc/sort_scheduler.md
SORT_SCHEDULER -- requirements
Module: sort_scheduler

Interface
REQ-001 Parameter N, default 8, number of words per sort frame; SHALL be even and >= 4.
REQ-002 Parameter W, default 8, data word width.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 in_valid  input  1  in_data holds a valid word.
REQ-006 in_data  input  W  word to load into the frame.
REQ-007 in_ready  output  1  block accepts a word this cycle.
REQ-008 cmp_a  output  W  operand to the shared compare node in_1.
REQ-009 cmp_b  output  W  operand to the shared compare node in_2.
REQ-010 cmp_high  input  W  compare node high result (in_1 when in_1 >= in_2).
REQ-011 cmp_low  input  W  compare node low result.
REQ-012 out_valid  output  1  out_data holds a sorted word.
REQ-013 out_data  output  W  sorted word, descending order.
REQ-014 out_last  output  1  marks the final word of the frame.
REQ-015 out_ready  input  1  consumer accepts out_data this cycle.
REQ-016 busy  output  1  high in SORT and DRAIN.

Function
REQ-017 FSM states: LOAD, SORT, DRAIN; N-entry W-bit buffer buf[0..N-1].
REQ-018 LOAD: in_ready=1; on in_valid&&in_ready write buf[wr_idx], wr_idx++; the Nth accepted word SHALL move to SORT next cycle.
REQ-019 SORT: odd-even transposition, passes p=0..N-1; even p compares pairs (0,1),(2,3)..; odd p compares (1,2),(3,4)..,(N-3,N-2).
REQ-020 SORT: exactly one pair i,i+1 per cycle; cmp_a=buf[i], cmp_b=buf[i+1] combinationally; same edge writes buf[i]=cmp_high, buf[i+1]=cmp_low.
REQ-021 Even pass = N/2 cycles, odd pass = N/2-1 cycles; full sort = N*(N-1)/2 cycles (28 for N=8).
REQ-022 Outside SORT, cmp_a and cmp_b SHALL be 0.
REQ-023 After the final pass cycle, move to DRAIN.
REQ-024 DRAIN: out_valid=1, out_data=buf[rd_idx], out_last=(rd_idx==N-1); on out_valid&&out_ready rd_idx++.
REQ-025 out_data SHALL hold stable while out_valid&&!out_ready.
REQ-026 Handshake on out_last SHALL return to LOAD next cycle with wr_idx=rd_idx=0.
REQ-027 in_ready=0 in SORT and DRAIN; in_valid there is ignored, no words lost into the next frame.
REQ-028 Equal operands SHALL not count as a swap (cmp_high equals cmp_a).
REQ-029 Latency: last input accepted in cycle t -> first out_valid in cycle t+1+N*(N-1)/2.

Reset
REQ-030 rst high SHALL immediately force LOAD, wr_idx=rd_idx=pass=pair=0, buf all 0.
REQ-031 During and after reset: in_ready=1 (after release), out_valid=0, out_last=0, out_data=0, busy=0, cmp_a=cmp_b=0.
REQ-032 Reset mid-frame (any state) SHALL discard the partial frame; no out_valid until a full new frame is loaded and sorted.

Configuration
REQ-033 Macro SORT_EARLY_EXIT_EN: when defined, a swap flag tracks each even+odd pass pair; if no swap occurred in both, SORT SHALL end after that odd pass and enter DRAIN.
REQ-034 Without SORT_EARLY_EXIT_EN, SORT always runs all N passes; output data identical in both builds, only latency differs.

Verification
REQ-035 Load 3,7,1,9,9,0,255,4 (N=8), out_ready=1 -> outputs 255,9,9,7,4,3,1,0, out_last on 0, first out_valid 29 cycles after last accept (no macro).
REQ-036 Load descending 80..10 step 10, SORT_EARLY_EXIT_EN defined -> no swaps, first out_valid 8 cycles after last accept; without macro, 29.
REQ-037 DRAIN with out_ready toggling 1,0,0,1.. -> each word held while stalled, no duplicates/drops, exactly 8 handshakes.
REQ-038 in_valid held high through SORT/DRAIN -> in_ready=0, no writes; next frame starts clean after out_last.
REQ-039 Assert rst in SORT after 10 cycles -> all outputs reset values immediately; new frame 1..8 yields 8..1.
REQ-040 All-equal frame 5x8 -> eight 5s, early-exit build ends SORT after 7 cycles.
